// File: rtl/game_pkg.sv
// Shared game-core geometry, shot tuning constants and the projectile slot record.
// Latency: none (types and constants only).
// Backpressure: not applicable; everything here is consumed once per frame.
package game_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int PLAYERSHIP_W = 30;
  localparam int PLAYERSHIP_H = 30;
  localparam int BOSS_W       = 230;
  localparam int BOSS_H       = 100;

  localparam int SHOT_W       = 4;
  localparam int SHOT_H       = 10;
  localparam int SHOT_SPEED   = 8;
  localparam int COOLDOWN     = 15;
  localparam int NUM_SHOTS    = 4;

  // Horizontal offset that centres a shot on the ship: 30/2 - 4/2 = 13.
  localparam int SHOT_X_OFF   = PLAYERSHIP_W / 2 - SHOT_W / 2;

  typedef struct packed {
    logic       exists;
    logic [9:0] x;
    logic [9:0] y;
  } shot_t;

  // Widen a screen coordinate so that coordinate + box size cannot overflow.
  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/shot_slot.sv
// One projectile register: launch load, upward move, off-top retire, boss collision.
// Latency: hit is combinational from the registered position; state updates each frame.
// Backpressure: none; launch is only offered by the parent while the slot is empty.
module shot_slot
  import game_pkg::*;
#(
  parameter int SPEED = SHOT_SPEED,
  parameter int SW    = SHOT_W,
  parameter int SH    = SHOT_H,
  parameter int BW    = BOSS_W,
  parameter int BH    = BOSS_H
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       launch,
  input  logic [9:0] launch_x,
  input  logic [9:0] launch_y,
  input  logic       boss_exists,
  input  logic [9:0] bsX,
  input  logic [9:0] bsY,
  output shot_t      shot,
  output logic       hit
);

  logic [10:0] x11, y11, bx11, by11;

  // Box overlap against the boss, evaluated on the position before this frame's move.
  always_comb begin
    x11  = ext11(shot.x);
    y11  = ext11(shot.y);
    bx11 = ext11(bsX);
    by11 = ext11(bsY);
    hit  = shot.exists && boss_exists &&
           (x11 + 11'(SW) > bx11) && (x11 < bx11 + 11'(BW)) &&
           (y11 < by11 + 11'(BH)) && (y11 + 11'(SH) > by11);
  end

  // Slot state: collision beats off-top retire beats the move; X is frozen after launch.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      shot <= '0;
    end else if (launch) begin
      shot.exists <= 1'b1;
      shot.x      <= launch_x;
      shot.y      <= launch_y;
    end else if (shot.exists) begin
      if (hit) begin
        shot.exists <= 1'b0;
      end else if (shot.y < 10'(SPEED)) begin
        shot.exists <= 1'b0;
      end else begin
        shot.y <= shot.y - 10'(SPEED);
      end
    end
  end

endmodule

// File: rtl/player_laser.sv
// Player weapon: launches shots on fire-button edges and reports hits on the boss.
// Latency: launch visible 1 frame after the fire edge; Bhit/hit_count 1 frame after collision.
// Backpressure: fire edges during cooldown or with all slots busy are dropped, never queued.
module player_laser
  import game_pkg::*;
#(
  parameter int NUM_SHOTS  = game_pkg::NUM_SHOTS,
  parameter int SHOT_SPEED = game_pkg::SHOT_SPEED,
  parameter int COOLDOWN   = game_pkg::COOLDOWN,
  parameter int SHOT_W     = game_pkg::SHOT_W,
  parameter int SHOT_H     = game_pkg::SHOT_H,
  parameter int BOSS_W     = game_pkg::BOSS_W,
  parameter int BOSS_H     = game_pkg::BOSS_H
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    fire,
  input  logic [9:0]              PSX,
  input  logic [9:0]              PSY,
  input  logic [9:0]              bsX,
  input  logic [9:0]              bsY,
  input  logic                    boss_exists,
  output logic [NUM_SHOTS*10-1:0] shotX,
  output logic [NUM_SHOTS*10-1:0] shotY,
  output logic [NUM_SHOTS-1:0]    shot_exists,
  output logic                    Bhit,
  output logic [7:0]              hit_count
);

  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam int CNT_W = $clog2(NUM_SHOTS + 1);

  logic                 fire_q;
  logic                 fire_edge;
  logic [CD_W-1:0]      cooldown;
  logic                 launch_ok;
  logic [NUM_SHOTS-1:0] free_sel;
  logic                 any_free;
  logic [NUM_SHOTS-1:0] launch_vec;
  logic [NUM_SHOTS-1:0] hit_vec;
  logic [CNT_W-1:0]     hit_num;
  logic [8:0]           hit_sum;
  logic [9:0]           launch_x;
  logic [9:0]           launch_y;
  shot_t                slots [NUM_SHOTS];

  assign launch_x = PSX + 10'(SHOT_X_OFF);
  assign launch_y = PSY - 10'(SHOT_H);

  // Fire-button history; reset value of 1 keeps a button held through reset from firing.
  always_ff @(posedge frame_clk) begin
    if (!Reset) fire_q <= 1'b1;
    else        fire_q <= fire;
  end

  assign fire_edge = fire && !fire_q;

  // Lowest-index empty slot wins the launch.
  always_comb begin
    free_sel = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (!any_free && !slots[i].exists) begin
        free_sel[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
  end

  assign launch_ok  = fire_edge && (cooldown == '0) && any_free;
  assign launch_vec = launch_ok ? free_sel : '0;

  // Cooldown reloads on a launch and otherwise counts down to zero; a full-slot edge leaves it alone.
  always_ff @(posedge frame_clk) begin
    if (!Reset)              cooldown <= '0;
    else if (launch_ok)      cooldown <= CD_W'(COOLDOWN);
    else if (cooldown != '0) cooldown <= cooldown - 1'b1;
  end

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    shot_slot #(
      .SPEED (SHOT_SPEED),
      .SW    (SHOT_W),
      .SH    (SHOT_H),
      .BW    (BOSS_W),
      .BH    (BOSS_H)
    ) u_slot (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .launch      (launch_vec[g]),
      .launch_x    (launch_x),
      .launch_y    (launch_y),
      .boss_exists (boss_exists),
      .bsX         (bsX),
      .bsY         (bsY),
      .shot        (slots[g]),
      .hit         (hit_vec[g])
    );

    assign shotX[10*g +: 10] = slots[g].x;
    assign shotY[10*g +: 10] = slots[g].y;
    assign shot_exists[g]    = slots[g].exists;
  end

  // Number of slots colliding this frame, and the unsaturated running total.
  always_comb begin
    hit_num = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      hit_num = hit_num + CNT_W'(hit_vec[i]);
    end
    hit_sum = {1'b0, hit_count} + 9'(hit_num);
  end

  // Registered hit pulse and saturating hit counter; reset wins over a same-frame collision.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      Bhit      <= 1'b0;
      hit_count <= '0;
    end else begin
      Bhit      <= |hit_vec;
      hit_count <= hit_sum[8] ? 8'hFF : hit_sum[7:0];
    end
  end

endmodule

// File: tb/tb_player_laser.sv
module tb_player_laser;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        fire;
  logic [9:0]  PSX, PSY, bsX, bsY;
  logic        boss_exists;
  logic [39:0] shotX, shotY;
  logic [3:0]  shot_exists;
  logic        Bhit;
  logic [7:0]  hit_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 frame_clk = ~frame_clk;

  player_laser dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .fire        (fire),
    .PSX         (PSX),
    .PSY         (PSY),
    .bsX         (bsX),
    .bsY         (bsY),
    .boss_exists (boss_exists),
    .shotX       (shotX),
    .shotY       (shotY),
    .shot_exists (shot_exists),
    .Bhit        (Bhit),
    .hit_count   (hit_count)
  );

  // Advance one frame and settle just after the edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with the observed value.
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%0d expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
  endtask

  // Fire edge followed by enough idle frames for the cooldown to return to zero.
  task automatic launch_wait();
    fire = 1'b1;
    step();
    fire = 1'b0;
    repeat (15) step();
  endtask

  function automatic logic [9:0] sy(input int i);
    return shotY[10*i +: 10];
  endfunction

  function automatic logic [9:0] sx(input int i);
    return shotX[10*i +: 10];
  endfunction

  // Two shots brought to the same spot with the boss hidden, then the boss appears.
  task automatic double_hit(input int exp_count);
    boss_exists = 1'b0;
    bsX = 10'd200;
    bsY = 10'd250;
    PSY = 10'd440;
    launch_wait();              // slot 0 launched at 430, now 310
    PSY = 10'd312;
    fire = 1'b1;
    step();                     // slot 0 moves to 302, slot 1 launched at 302
    fire = 1'b0;
    expect_val(302); check("dbl_y0", 32'(sy(0)));
    expect_val(302); check("dbl_y1", 32'(sy(1)));
    boss_exists = 1'b1;
    step();
    expect_val(0); check("dbl_exists", 32'(shot_exists));
    expect_val(1); check("dbl_bhit", 32'(Bhit));
    expect_val(exp_count); check("dbl_count", 32'(hit_count));
    step();
    expect_val(0); check("dbl_bhit_drop", 32'(Bhit));
    PSY = 10'd440;
  endtask

  initial begin
    int prev, cur, n, pulses;
    bit seen;

    Reset = 1'b0; fire = 1'b1;
    PSX = 10'd300; PSY = 10'd440;
    bsX = 10'd200; bsY = 10'd20; boss_exists = 1'b0;
    repeat (2) step();

    // Reset state
    expect_val(0); check("rst_exists", 32'(shot_exists));
    expect_val(0); check("rst_bhit", 32'(Bhit));
    expect_val(0); check("rst_count", 32'(hit_count));
    expect_val(0); check("rst_x0", 32'(sx(0)));
    expect_val(0); check("rst_y0", 32'(sy(0)));

    // Fire held through reset release does not launch
    Reset = 1'b1;
    repeat (3) step();
    expect_val(0); check("held_fire", 32'(shot_exists));

    // Release, press: slot 0 at (313,430)
    fire = 1'b0; step();
    fire = 1'b1; step();
    fire = 1'b0;
    expect_val(1);   check("first_exists", 32'(shot_exists));
    expect_val(313); check("first_x", 32'(sx(0)));
    expect_val(430); check("first_y", 32'(sy(0)));

    // Free flight with no boss: 53 moves to Y=6, then retire
    seen = 1'b0;
    repeat (53) begin
      step();
      if (Bhit) seen = 1'b1;
    end
    expect_val(6); check("fly_last_y", 32'(sy(0)));
    expect_val(1); check("fly_last_exists", 32'(shot_exists));
    step();
    if (Bhit) seen = 1'b1;
    expect_val(0); check("fly_retired", 32'(shot_exists));
    expect_val(6); check("fly_keep_y", 32'(sy(0)));
    expect_val(0); check("fly_no_bhit", 32'(seen));

    // Fire edges every other frame for 40 frames: launches at 0, 16, 32
    expect_val(0); expect_val(16); expect_val(32);
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      fire = (i % 2 == 0);
      step();
      cur = $countones(shot_exists);
      if (cur > prev) check("launch_frame", 32'(i));
      prev = cur;
    end
    fire = 1'b0;
    n = exp_q.size();
    expect_val(0); check("launch_left", 32'(n));
    expect_val(7);   check("cd_exists", 32'(shot_exists));
    expect_val(118); check("cd_y0", 32'(sy(0)));
    expect_val(246); check("cd_y1", 32'(sy(1)));
    expect_val(374); check("cd_y2", 32'(sy(2)));

    // Reset mid-flight clears everything
    do_reset();
    expect_val(0); check("mid_rst_exists", 32'(shot_exists));
    expect_val(0); check("mid_rst_y0", 32'(sy(0)));
    step();

    // All four slots busy: edge dropped, cooldown untouched
    PSY = 10'd560; launch_wait();
    PSY = 10'd1000; launch_wait(); launch_wait(); launch_wait();
    expect_val(15); check("full_exists", 32'(shot_exists));
    expect_val(46); check("full_y0", 32'(sy(0)));
    fire = 1'b1; step(); fire = 1'b0;
    expect_val(15); check("full_no_launch", 32'(shot_exists));
    n = 0;
    while (shot_exists[0] && n < 20) begin step(); n++; end
    expect_val(5); check("full_retire_wait", 32'(n));
    fire = 1'b1; step(); fire = 1'b0;
    expect_val(15);  check("refill_exists", 32'(shot_exists));
    expect_val(990); check("refill_y0", 32'(sy(0)));
    expect_val(313); check("refill_x0", 32'(sx(0)));

    // Collision with boss at (200,20)
    do_reset();
    step();
    PSY = 10'd440; bsX = 10'd200; bsY = 10'd20; boss_exists = 1'b1;
    fire = 1'b1; step(); fire = 1'b0;
    expect_val(430); check("col_launch_y", 32'(sy(0)));
    n = 0; pulses = 0;
    while (shot_exists[0] && n < 100) begin
      step(); n++;
      if (Bhit) pulses++;
    end
    expect_val(1); check("col_bhit_now", 32'(Bhit));
    repeat (3) begin step(); if (Bhit) pulses++; end
    expect_val(40);  check("col_frames", 32'(n));
    expect_val(1);   check("col_pulses", 32'(pulses));
    expect_val(1);   check("col_count", 32'(hit_count));
    expect_val(118); check("col_keep_y", 32'(sy(0)));

    // Same geometry with the boss absent: no hit, retires off the top
    boss_exists = 1'b0;
    fire = 1'b1; step(); fire = 1'b0;
    n = 0; pulses = 0;
    while (shot_exists[0] && n < 100) begin
      step(); n++;
      if (Bhit) pulses++;
    end
    expect_val(54); check("nob_frames", 32'(n));
    expect_val(0);  check("nob_pulses", 32'(pulses));
    expect_val(1);  check("nob_count", 32'(hit_count));
    expect_val(6);  check("nob_last_y", 32'(sy(0)));

    // Two shots hit in the same frame
    double_hit(3);

    // Single hits right at the launch point up to 254
    repeat (15) step();
    bsX = 10'd200; bsY = 10'd400; boss_exists = 1'b1; PSY = 10'd440;
    repeat (251) launch_wait();
    expect_val(254); check("pre_sat_count", 32'(hit_count));

    // Double hit from 254 saturates
    double_hit(255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
